// File: rtl/dct_transpose_pkg.sv
// Shared types and constants for the DCT transpose stage.
package dct_transpose_pkg;

    localparam int DCT_BLK        = 8;
    localparam int DCT_DATA_WIDTH = 10;

    typedef struct packed {
        logic [DCT_DATA_WIDTH-1:0] data;
        logic                      valid;
    } dctPort_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Row-major storage read in column-major order: row=cnt[2:0], col=cnt[5:3].
    function automatic logic [5:0] transpose_addr(input logic [5:0] cnt);
        return {cnt[2:0], cnt[5:3]};
    endfunction

endpackage

// File: rtl/transpose_bank.sv
// One 64-entry sample bank: synchronous write, combinational read.
module transpose_bank #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dct_transpose.sv
// Ping-pong 8x8 transpose buffer: row-major samples in, column-major samples out.
module dct_transpose
    import dct_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_WIDTH,
    parameter int N          = DCT_BLK
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  dctPort_t in,
    output dctPort_t out,
    output logic     busy
);

    localparam logic [5:0] LAST = 6'(N * N - 1);

    rd_state_t             state;
    logic [5:0]            wcnt;
    logic [5:0]            rcnt;
    logic                  wbank;
    logic                  rbank;
    logic [1:0]            full;

    logic                  wr_en;
    logic                  wr_last;
    logic                  rd_en;
    logic                  rd_last;
    logic [1:0]            full_set;
    logic [1:0]            full_clr;
    logic [5:0]            raddr;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic [DATA_WIDTH-1:0] rdata;

    // A sample aimed at a still-full bank is dropped rather than corrupting it.
    always_comb begin
        wr_en    = in.valid & ~full[wbank];
        wr_last  = wr_en & (wcnt == LAST);
        rd_en    = (state == RD_READ) | full[rbank];
        rd_last  = rd_en & (rcnt == LAST);
        full_set = '0;
        full_clr = '0;
        if (wr_last) full_set[wbank] = 1'b1;
        if (rd_last) full_clr[rbank] = 1'b1;
        raddr    = transpose_addr(rcnt);
        rdata    = rbank ? rdata_b : rdata_a;
    end

    transpose_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(6)) u_bank_a (
        .clk   (clk),
        .we    (wr_en & ~clr & ~wbank),
        .waddr (wcnt),
        .wdata (in.data),
        .raddr (raddr),
        .rdata (rdata_a)
    );

    transpose_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(6)) u_bank_b (
        .clk   (clk),
        .we    (wr_en & ~clr & wbank),
        .waddr (wcnt),
        .wdata (in.data),
        .raddr (raddr),
        .rdata (rdata_b)
    );

    // Entry 0 is read in the IDLE cycle that first sees a full bank, giving the
    // two-cycle latency; a bank filling during the last read keeps READ seamless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
            wcnt  <= '0;
            rcnt  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= '0;
            out   <= '0;
        end else if (clr) begin
            state     <= RD_IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            full      <= '0;
            out.valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wcnt <= wcnt + 6'd1;
                if (wr_last) wbank <= ~wbank;
            end
            full <= (full | full_set) & ~full_clr;
            if (rd_en) begin
                out.data  <= rdata;
                out.valid <= 1'b1;
                rcnt      <= rcnt + 6'd1;
                if (rd_last) begin
                    rbank <= ~rbank;
                    state <= (full[~rbank] | full_set[~rbank]) ? RD_READ : RD_IDLE;
                end else begin
                    state <= RD_READ;
                end
            end else begin
                out.valid <= 1'b0;
                state     <= RD_IDLE;
            end
        end
    end

    assign busy = (|full) | (state == RD_READ);

    overflow_drop: assert property (@(posedge clk) disable iff (!rst_n)
        !(in.valid && !clr && full[wbank]));

endmodule

// File: tb/tb_dct_transpose.sv
// Directed self-checking bench for dct_transpose.
module tb_dct_transpose;
    import dct_transpose_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     clr = 1'b0;
    dctPort_t in_port = '0;
    dctPort_t out_port;
    logic     busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0] oq[$];
    int         tq[$];

    dct_transpose #(.DATA_WIDTH(10), .N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .in    (in_port),
        .out   (out_port),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_port.valid) begin
            oq.push_back(out_port.data);
            tq.push_back(cyc);
        end
    end

    function automatic int exp_val(input int base, input int i);
        return base + (i % 8) * 8 + (i / 8);
    endfunction

    task automatic drive(input logic v, input logic [9:0] d);
        @(negedge clk);
        in_port.valid = v;
        in_port.data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 10'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10'($urandom_range(0, 1023)));
            #1;
            total++;
            if (out_port.valid !== 1'b0) begin
                bad++; $display("FAIL reset_valid: got %b want 0", out_port.valid);
            end
            total++;
            if (out_port.data !== 10'd0) begin
                bad++; $display("FAIL reset_data: got %0d want 0", out_port.data);
            end
            total++;
            if (busy !== 1'b0) begin
                bad++; $display("FAIL reset_busy: got %b want 0", busy);
            end
        end
        drive(1'b0, 10'd0);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_block();
        int c_last;
        oq.delete(); tq.delete();
        for (int i = 0; i < 64; i++) drive(1'b1, 10'(i));
        c_last = cyc;
        drive(1'b0, 10'd0);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL single_busy_high: got %b want 1", busy);
        end
        idle(80);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_busy_low: got %b want 0", busy);
        end
        total++;
        if (oq.size() != 64) begin
            bad++; $display("FAIL single_count: got %0d want 64", oq.size());
        end
        if (oq.size() > 0) begin
            total++;
            if (tq[0] != c_last + 2) begin
                bad++; $display("FAIL single_latency: got %0d want %0d", tq[0], c_last + 2);
            end
        end
        for (int i = 0; i < 64 && i < oq.size(); i++) begin
            total++;
            if (tq[i] != tq[0] + i) begin
                bad++; $display("FAIL single_contig[%0d]: got %0d want %0d", i, tq[i], tq[0] + i);
            end
            total++;
            if (oq[i] !== 10'(exp_val(0, i))) begin
                bad++; $display("FAIL single_data[%0d]: got %0d want %0d", i, oq[i], exp_val(0, i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c_first;
        oq.delete(); tq.delete();
        c_first = 0;
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 10'(i));
            if (i == 63) c_first = cyc;
        end
        idle(150);
        total++;
        if (oq.size() != 128) begin
            bad++; $display("FAIL b2b_count: got %0d want 128", oq.size());
        end
        if (oq.size() > 0) begin
            total++;
            if (tq[0] != c_first + 2) begin
                bad++; $display("FAIL b2b_latency: got %0d want %0d", tq[0], c_first + 2);
            end
        end
        for (int i = 0; i < 128 && i < oq.size(); i++) begin
            total++;
            if (tq[i] != tq[0] + i) begin
                bad++; $display("FAIL b2b_contig[%0d]: got %0d want %0d", i, tq[i], tq[0] + i);
            end
            total++;
            if (oq[i] !== 10'(exp_val((i / 64) * 64, i % 64))) begin
                bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, oq[i],
                                exp_val((i / 64) * 64, i % 64));
            end
        end
    endtask

    task automatic test_gapped();
        int c_last;
        oq.delete(); tq.delete();
        c_last = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 10'(200 + i));
            c_last = cyc;
            if (i < 63) drive(1'b0, 10'd0);
        end
        idle(80);
        total++;
        if (oq.size() != 64) begin
            bad++; $display("FAIL gap_count: got %0d want 64", oq.size());
        end
        if (oq.size() > 0) begin
            total++;
            if (tq[0] != c_last + 2) begin
                bad++; $display("FAIL gap_latency: got %0d want %0d", tq[0], c_last + 2);
            end
        end
        for (int i = 0; i < 64 && i < oq.size(); i++) begin
            total++;
            if (tq[i] != tq[0] + i) begin
                bad++; $display("FAIL gap_contig[%0d]: got %0d want %0d", i, tq[i], tq[0] + i);
            end
            total++;
            if (oq[i] !== 10'(exp_val(200, i))) begin
                bad++; $display("FAIL gap_data[%0d]: got %0d want %0d", i, oq[i], exp_val(200, i));
            end
        end
    endtask

    task automatic test_clr_mid_block();
        oq.delete(); tq.delete();
        for (int i = 0; i < 20; i++) drive(1'b1, 10'(500 + i));
        @(negedge clk);
        clr = 1'b1;
        in_port.valid = 1'b1;
        in_port.data  = 10'd999;
        @(negedge clk);
        clr = 1'b0;
        in_port.valid = 1'b0;
        for (int i = 0; i < 64; i++) drive(1'b1, 10'(100 + i));
        idle(80);
        total++;
        if (oq.size() != 64) begin
            bad++; $display("FAIL clr_count: got %0d want 64", oq.size());
        end
        for (int i = 0; i < 64 && i < oq.size(); i++) begin
            total++;
            if (oq[i] !== 10'(exp_val(100, i))) begin
                bad++; $display("FAIL clr_data[%0d]: got %0d want %0d", i, oq[i], exp_val(100, i));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit reached;
        int n;
        oq.delete(); tq.delete();
        reached = 1'b0;
        for (int i = 0; i < 64; i++) drive(1'b1, 10'(300 + i));
        for (int i = 0; i < 100 && !reached; i++) begin
            drive(1'b0, 10'd0);
            #1;
            if (oq.size() >= 10) reached = 1'b1;
        end
        total++;
        if (!reached) begin
            bad++; $display("FAIL rmr_reach: got %0d samples want 10", oq.size());
        end
        total++;
        if (out_port.valid !== 1'b1) begin
            bad++; $display("FAIL rmr_valid_before: got %b want 1", out_port.valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_port.valid !== 1'b0) begin
            bad++; $display("FAIL rmr_valid_async: got %b want 0", out_port.valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rmr_busy_async: got %b want 0", busy);
        end
        idle(2);
        rst_n = 1'b1;
        n = oq.size();
        idle(80);
        total++;
        if (oq.size() != n) begin
            bad++; $display("FAIL rmr_no_output: got %0d want %0d", oq.size(), n);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rmr_busy_after: got %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_gapped();
        test_clr_mid_block();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
